cms_loader: RTL and testbench

- Boot-time sequencer that fetches the 128-bit chip-mode-selection pattern from the shared NVM read port and hands it to the cms block on its cmsdata/cmsdatavld inputs.
- Reads two redundant copies and compares them, retrying on mismatch, NVM error or timeout.
- Publishes exactly one pattern per reset epoch: the matched data on success, or an all-ones scrub pattern on failure, which the mode decoder resolves to the SCDE mode.

---
 rtl/cms_pkg.sv | 31 +++
 rtl/cms_nvm_rd.sv | 87 ++++++++
 rtl/cms_loader.sv | 207 ++++++++++++++++++++
 tb/tb_cms_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cms_pkg.sv
// Shared types and constants for the chip-mode-selection loader path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cms_pkg;

    // Width of the chip-mode-selection pattern handed to the cms block.
    localparam int CMSDW = 128;

    // Published on load failure; the mode decoder resolves all-ones to SCDE.
    localparam logic [CMSDW-1:0] CMSDAT_SCRUB = '1;

    // Loader sequencer states.
    typedef enum logic [2:0] {
        CMSLD_IDLE = 3'd0,
        CMSLD_RDA  = 3'd1,
        CMSLD_RDB  = 3'd2,
        CMSLD_CMP  = 3'd3,
        CMSLD_PUB  = 3'd4,
        CMSLD_DONE = 3'd5,
        CMSLD_FAIL = 3'd6
    } cmsld_state_e;

    // Number of NVM words per pattern copy for a given read width.
    function automatic int cmsld_words(input int dw);
        return CMSDW / dw;
    endfunction

    // Word count for the standard 32-bit NVM read port.
    localparam int CMSLD_WORDS = CMSDW / 32;

endpackage

// File: rtl/cms_nvm_rd.sv
// Single-word NVM read: raises nvm_req on rd_start, waits for nvm_ack or timeout.
// Latency: result flags/data one cycle after the ack (or timeout) cycle.
// Backpressure: rd_start is only honoured while no request is outstanding; the ack cycle drop gives a mandatory idle gap.
module cms_nvm_rd #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_start,
    input  logic [AW-1:0] rd_addr,
    output logic          nvm_req,
    output logic [AW-1:0] nvm_addr,
    input  logic          nvm_ack,
    input  logic [DW-1:0] nvm_rdata,
    input  logic          nvm_err,
    output logic          rdone,
    output logic          rfail,
    output logic [DW-1:0] rdata
);

    // Last count value before the request is abandoned; the request stays up
    // for exactly TIMEOUT cycles when no ack arrives.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic          req_q,   req_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [7:0]    tcnt_q,  tcnt_d;
    logic          rdone_q, rdone_d;
    logic          rfail_q, rfail_d;
    logic [DW-1:0] rdata_q, rdata_d;

    // Handshake: hold req until ack or timeout; a new start is only taken
    // while req is low, so the drop cycle always separates two requests.
    always_comb begin
        req_d   = req_q;
        addr_d  = addr_q;
        tcnt_d  = tcnt_q;
        rdone_d = 1'b0;
        rfail_d = 1'b0;
        rdata_d = rdata_q;
        if (req_q) begin
            if (nvm_ack) begin
                req_d   = 1'b0;
                rdone_d = ~nvm_err;
                rfail_d = nvm_err;
                rdata_d = nvm_rdata;
            end else if (tcnt_q == TMO_LAST) begin
                req_d   = 1'b0;
                rfail_d = 1'b1;
            end else begin
                tcnt_d = tcnt_q + 8'd1;
            end
        end else if (rd_start) begin
            req_d  = 1'b1;
            addr_d = rd_addr;
            tcnt_d = 8'd0;
        end
    end

    // State registers; reset pulls nvm_req low immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q   <= 1'b0;
            addr_q  <= '0;
            tcnt_q  <= 8'd0;
            rdone_q <= 1'b0;
            rfail_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            req_q   <= req_d;
            addr_q  <= addr_d;
            tcnt_q  <= tcnt_d;
            rdone_q <= rdone_d;
            rfail_q <= rfail_d;
            rdata_q <= rdata_d;
        end
    end

    assign nvm_req  = req_q;
    assign nvm_addr = addr_q;
    assign rdone    = rdone_q;
    assign rfail    = rfail_q;
    assign rdata    = rdata_q;

endmodule

// File: rtl/cms_loader.sv
// Boot loader: reads two NVM copies of the cms pattern, compares, retries, publishes once per reset.
// Latency: zero-wait NVM gives cmsdatavld 18 cycles after the first nvm_req.
// Backpressure: NVM stalls are absorbed by the per-word timeout; the cms side has no backpressure.
module cms_loader import cms_pkg::*; #(
    parameter int            AW       = 16,
    parameter int            DW       = 32,
    parameter logic [AW-1:0] BASEA    = 'h0000,
    parameter logic [AW-1:0] BASEB    = 'h0010,
    parameter int            MAXRETRY = 3,
    parameter int            TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             nvm_req,
    output logic [AW-1:0]    nvm_addr,
    input  logic             nvm_ack,
    input  logic [DW-1:0]    nvm_rdata,
    input  logic             nvm_err,
    output logic [CMSDW-1:0] cmsdata,
    output logic             cmsdatavld,
    output logic             busy,
    output logic             done,
    output logic             loaderror,
    output logic [3:0]       retrycnt
);

    localparam int         WORDS = cmsld_words(DW);
    localparam int         IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    cmsld_state_e     state_q, state_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic [CMSDW-1:0] buf_a_q, buf_a_d;
    logic [CMSDW-1:0] buf_b_q, buf_b_d;
    logic [CMSDW-1:0] cmsdata_q, cmsdata_d;
    logic             vld_q,   vld_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             lerr_q,  lerr_d;
    logic [3:0]       retry_q, retry_d;

    logic             rd_start;
    logic [AW-1:0]    rd_addr;
    logic             rdone;
    logic             rfail;
    logic [DW-1:0]    rdata;
    logic             fail_att;

    cms_nvm_rd #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) u_rd (
        .clk       (clk),
        .reset     (reset),
        .rd_start  (rd_start),
        .rd_addr   (rd_addr),
        .nvm_req   (nvm_req),
        .nvm_addr  (nvm_addr),
        .nvm_ack   (nvm_ack),
        .nvm_rdata (nvm_rdata),
        .nvm_err   (nvm_err),
        .rdone     (rdone),
        .rfail     (rfail),
        .rdata     (rdata)
    );

    // Sequencer next state: word reads for A then B, compare, then publish
    // either the matched copy or the scrub pattern; any failed attempt
    // clears both buffers and restarts at copy A until retries run out.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        buf_a_d   = buf_a_q;
        buf_b_d   = buf_b_q;
        cmsdata_d = cmsdata_q;
        vld_d     = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;
        lerr_d    = lerr_q;
        retry_d   = retry_q;
        rd_start  = 1'b0;
        rd_addr   = BASEA;
        fail_att  = 1'b0;
        case (state_q)
            CMSLD_IDLE: begin
                if (start && !done_q) begin
                    state_d  = CMSLD_RDA;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    rd_start = 1'b1;
                    rd_addr  = BASEA;
                end
            end
            CMSLD_RDA: begin
                if (rdone) begin
                    buf_a_d[idx_q*DW +: DW] = rdata;
                    rd_start = 1'b1;
                    if (idx_q == LAST) begin
                        state_d = CMSLD_RDB;
                        idx_d   = '0;
                        rd_addr = BASEB;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        rd_addr = BASEA + AW'(idx_q) + AW'(1);
                    end
                end else if (rfail) begin
                    fail_att = 1'b1;
                end
            end
            CMSLD_RDB: begin
                if (rdone) begin
                    buf_b_d[idx_q*DW +: DW] = rdata;
                    if (idx_q == LAST) begin
                        state_d = CMSLD_CMP;
                        idx_d   = '0;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        rd_start = 1'b1;
                        rd_addr  = BASEB + AW'(idx_q) + AW'(1);
                    end
                end else if (rfail) begin
                    fail_att = 1'b1;
                end
            end
            CMSLD_CMP: begin
                if (buf_a_q == buf_b_q) begin
                    state_d = CMSLD_PUB;
                end else begin
                    fail_att = 1'b1;
                end
            end
            CMSLD_PUB: begin
                cmsdata_d = buf_a_q;
                vld_d     = 1'b1;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                state_d   = CMSLD_DONE;
            end
            CMSLD_FAIL: begin
                cmsdata_d = CMSDAT_SCRUB;
                vld_d     = 1'b1;
                lerr_d    = 1'b1;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                state_d   = CMSLD_DONE;
            end
            CMSLD_DONE: begin
                state_d = CMSLD_DONE;
            end
            default: begin
                state_d = CMSLD_IDLE;
            end
        endcase

        if (fail_att) begin
            buf_a_d = '0;
            buf_b_d = '0;
            idx_d   = '0;
            if (retry_q < 4'(MAXRETRY - 1)) begin
                retry_d  = retry_q + 4'd1;
                state_d  = CMSLD_RDA;
                rd_start = 1'b1;
                rd_addr  = BASEA;
            end else begin
                retry_d = 4'(MAXRETRY);
                state_d = CMSLD_FAIL;
            end
        end
    end

    // Sequencer and registered outputs; reset clears the whole epoch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CMSLD_IDLE;
            idx_q     <= '0;
            buf_a_q   <= '0;
            buf_b_q   <= '0;
            cmsdata_q <= '0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lerr_q    <= 1'b0;
            retry_q   <= 4'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            buf_a_q   <= buf_a_d;
            buf_b_q   <= buf_b_d;
            cmsdata_q <= cmsdata_d;
            vld_q     <= vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            lerr_q    <= lerr_d;
            retry_q   <= retry_d;
        end
    end

    assign cmsdata    = cmsdata_q;
    assign cmsdatavld = vld_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign loaderror  = lerr_q;
    assign retrycnt   = retry_q;

endmodule

// File: tb/tb_cms_loader.sv
// Bench for cms_loader: NVM model with per-attempt fault plans, reference outcome model, scoreboard.
// Latency: checks the 18-cycle zero-wait load and the 255-cycle request timeout.
// Backpressure: random NVM wait states and stray acks while no request is pending.
module tb_cms_loader;

    localparam int            AW       = 16;
    localparam int            DW       = 32;
    localparam logic [15:0]   BASEA    = 16'h0000;
    localparam logic [15:0]   BASEB    = 16'h0010;
    localparam int            MAXRETRY = 3;
    localparam int            TIMEOUT  = 255;
    localparam logic [127:0]  NOM      = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;

    // Per-attempt fault kinds; position 0..3 = copy A word, 4..7 = copy B word.
    localparam int K_NONE = 0;
    localparam int K_MIS  = 1;
    localparam int K_ERR  = 2;
    localparam int K_TMO  = 3;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          nvm_req;
    logic [AW-1:0] nvm_addr;
    logic          nvm_ack   = 1'b0;
    logic [DW-1:0] nvm_rdata = '0;
    logic          nvm_err   = 1'b0;
    logic [127:0]  cmsdata;
    logic          cmsdatavld;
    logic          busy;
    logic          done;
    logic          loaderror;
    logic [3:0]    retrycnt;

    cms_loader #(
        .AW       (AW),
        .DW       (DW),
        .BASEA    (BASEA),
        .BASEB    (BASEB),
        .MAXRETRY (MAXRETRY),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .nvm_req    (nvm_req),
        .nvm_addr   (nvm_addr),
        .nvm_ack    (nvm_ack),
        .nvm_rdata  (nvm_rdata),
        .nvm_err    (nvm_err),
        .cmsdata    (cmsdata),
        .cmsdatavld (cmsdatavld),
        .busy       (busy),
        .done       (done),
        .loaderror  (loaderror),
        .retrycnt   (retrycnt)
    );

    always #5 clk = ~clk;

    // NVM contents and per-run stimulus knobs
    logic [31:0] mem [0:31];
    int plan_kind [MAXRETRY];
    int plan_pos  [MAXRETRY];
    int mem_wait = 0;
    bit stray    = 1'b0;

    // Monitor state, cleared whenever reset is high
    int          cyc = 0;
    int          cur_att, req_age, n_reads, vld_cnt, vld_cyc, first_cyc;
    int          gap_viol, chg_viol, run_len, max_run;
    logic        req_prev, took_prev;
    logic [127:0] vld_dat, data_prev;
    logic [15:0] obs_addr [$];

    // Reference outcome
    logic [15:0]  exp_addr [$];
    bit           exp_fail;
    int           exp_retry;
    logic [127:0] exp_dat;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // NVM model plus bus monitor, both evaluated at the falling edge.
    always @(negedge clk) begin
        int a;
        int pos;
        cyc++;
        if (reset) begin
            cur_att = -1; req_age = 0; n_reads = 0; vld_cnt = 0; vld_cyc = 0; first_cyc = 0;
            gap_viol = 0; chg_viol = 0; run_len = 0; max_run = 0;
            req_prev = 1'b0; took_prev = 1'b0; vld_dat = '0; data_prev = cmsdata;
            obs_addr.delete();
            nvm_ack = 1'b0; nvm_err = 1'b0;
        end else begin
            if (cmsdatavld) begin
                vld_cnt++; vld_cyc = cyc; vld_dat = cmsdata;
            end
            if (cmsdata !== data_prev && !cmsdatavld) chg_viol++;
            data_prev = cmsdata;
            if (nvm_req && took_prev) gap_viol++;
            if (nvm_req) begin
                if (!req_prev) begin
                    n_reads++;
                    obs_addr.push_back(nvm_addr);
                    if (n_reads == 1) first_cyc = cyc;
                    if (nvm_addr == BASEA) cur_att++;
                    req_age = 0; run_len = 0;
                end
                run_len++;
                if (run_len > max_run) max_run = run_len;
                a   = (cur_att < 0) ? 0 : ((cur_att >= MAXRETRY) ? MAXRETRY - 1 : cur_att);
                pos = (nvm_addr >= BASEB) ? 4 + int'(nvm_addr) - int'(BASEB)
                                          : int'(nvm_addr) - int'(BASEA);
                if (plan_kind[a] == K_TMO && plan_pos[a] == pos) begin
                    nvm_ack = 1'b0; nvm_err = 1'b0;
                end else if (req_age >= mem_wait) begin
                    nvm_ack   = 1'b1;
                    nvm_err   = (plan_kind[a] == K_ERR && plan_pos[a] == pos);
                    nvm_rdata = mem[nvm_addr[4:0]];
                    if (plan_kind[a] == K_MIS && plan_pos[a] == pos) nvm_rdata = ~nvm_rdata;
                end else begin
                    nvm_ack = 1'b0; nvm_err = 1'b0;
                end
                req_age++;
            end else begin
                nvm_ack   = stray && ($urandom_range(0, 3) == 0);
                nvm_err   = 1'b1;
                nvm_rdata = $urandom;
            end
            took_prev = nvm_req && nvm_ack;
            req_prev  = nvm_req;
        end
    end

    // Outcome from the fault plan: reads issued per attempt, first clean
    // attempt wins, otherwise scrub after MAXRETRY attempts.
    function automatic void build_expect();
        exp_addr.delete();
        exp_fail  = 1'b1;
        exp_retry = MAXRETRY;
        for (int a = 0; a < MAXRETRY; a++) begin
            int n;
            n = (plan_kind[a] == K_ERR || plan_kind[a] == K_TMO) ? plan_pos[a] + 1 : 8;
            for (int p = 0; p < n; p++)
                exp_addr.push_back(p < 4 ? BASEA + 16'(p) : BASEB + 16'(p - 4));
            if (plan_kind[a] == K_NONE) begin
                exp_fail  = 1'b0;
                exp_retry = a;
                break;
            end
        end
        exp_dat = exp_fail ? {128{1'b1}}
                           : {mem[int'(BASEA)+3], mem[int'(BASEA)+2], mem[int'(BASEA)+1], mem[int'(BASEA)]};
    endfunction

    task automatic fill(input logic [127:0] pat);
        for (int k = 0; k < 4; k++) begin
            mem[int'(BASEA) + k] = pat[k*32 +: 32];
            mem[int'(BASEB) + k] = pat[k*32 +: 32];
        end
    endtask

    task automatic set_plan(input int k0, input int p0, input int k1, input int p1,
                            input int k2, input int p2);
        plan_kind[0] = k0; plan_pos[0] = p0;
        plan_kind[1] = k1; plan_pos[1] = p1;
        plan_kind[2] = k2; plan_pos[2] = p2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_done_timeout"}, 128'(n >= 6000), 128'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic verify(input string nm);
        build_expect();
        check({nm, "_vld_pulses"}, 128'(vld_cnt), 128'(1));
        check({nm, "_vld_data"}, vld_dat, exp_dat);
        check({nm, "_data_hold"}, cmsdata, exp_dat);
        check({nm, "_done"}, 128'(done), 128'(1));
        check({nm, "_busy"}, 128'(busy), 128'(0));
        check({nm, "_loaderror"}, 128'(loaderror), 128'(exp_fail));
        check({nm, "_retrycnt"}, 128'(retrycnt), 128'(exp_retry));
        check({nm, "_reads"}, 128'(obs_addr.size()), 128'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
            check($sformatf("%s_addr%0d", nm, i), 128'(obs_addr[i]), 128'(exp_addr[i]));
        check({nm, "_req_gap"}, 128'(gap_viol), 128'(0));
        check({nm, "_data_stable"}, 128'(chg_viol), 128'(0));
    endtask

    task automatic run(input string nm);
        do_reset();
        start = 1'b1;
        wait_done(nm);
        verify(nm);
    endtask

    initial begin
        int n;
        set_plan(K_NONE, 0, K_NONE, 0, K_NONE, 0);
        for (int i = 0; i < 32; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_req", 128'(nvm_req), 128'(0));
        check("rst_cmsdata", cmsdata, 128'(0));
        check("rst_vld", 128'(cmsdatavld), 128'(0));
        check("rst_status", 128'({busy, done, loaderror, retrycnt}), 128'(0));

        // Nominal zero-wait load, latency, then start toggling after done
        fill(NOM);
        mem_wait = 0;
        run("nominal");
        check("nominal_pattern", vld_dat, NOM);
        check("nominal_latency", 128'(vld_cyc - first_cyc), 128'(18));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = ~start;
        end
        repeat (5) @(negedge clk);
        check("restart_reads", 128'(n_reads), 128'(8));
        check("restart_vld", 128'(vld_cnt), 128'(1));
        check("restart_done", 128'(done), 128'(1));

        // Word 2 of copy B corrupted on the first attempt only
        set_plan(K_MIS, 6, K_NONE, 0, K_NONE, 0);
        run("mismatch");
        check("mismatch_pattern", vld_dat, NOM);

        // NVM never acknowledges: three timeouts then scrub
        set_plan(K_TMO, 0, K_TMO, 0, K_TMO, 0);
        run("timeout");
        check("timeout_req_len", 128'(max_run), 128'(TIMEOUT));

        // Error on copy A word 3 aborts before any B read
        set_plan(K_ERR, 3, K_NONE, 0, K_NONE, 0);
        run("nvmerr");

        // Reset while a copy B read is outstanding, then a clean reload
        set_plan(K_NONE, 0, K_NONE, 0, K_NONE, 0);
        mem_wait = 2;
        do_reset();
        start = 1'b1;
        n = 0;
        while (!(nvm_req && nvm_addr == BASEB + 16'd1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reach_rdb", 128'(n >= 2000), 128'(0));
        reset = 1'b1;
        #1;
        check("midrst_req", 128'(nvm_req), 128'(0));
        check("midrst_outs", 128'({cmsdatavld, busy, done, loaderror, retrycnt}), 128'(0));
        check("midrst_cmsdata", cmsdata, 128'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_done("midrst");
        verify("midrst");

        // Random data, wait states, stray acks and fault plans
        stray = 1'b1;
        for (int r = 0; r < 20; r++) begin
            fill({$urandom, $urandom, $urandom, $urandom});
            mem_wait = $urandom_range(0, 3);
            for (int a = 0; a < MAXRETRY; a++) begin
                int s;
                s = $urandom_range(0, 9);
                if (s < 5) begin
                    plan_kind[a] = K_NONE; plan_pos[a] = 0;
                end else if (s < 7) begin
                    plan_kind[a] = K_MIS;  plan_pos[a] = $urandom_range(4, 7);
                end else if (s < 9) begin
                    plan_kind[a] = K_ERR;  plan_pos[a] = $urandom_range(0, 7);
                end else begin
                    plan_kind[a] = K_TMO;  plan_pos[a] = $urandom_range(0, 7);
                end
            end
            run($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
